apb_master_arbiter: RTL

- Two-requester APB master. Shares one APB bus between the CPU data port (requester 0) and a secondary master such as DMA or debug (requester 1).
- Each requester uses the transfer/ready handshake that the multi-cycle control unit drives in its S_MEM and L_MEM states.
- Arbitrates between requesters, decodes the address to one of SLV_NUM slave selects, and sequences APB SETUP/ACCESS phases.
- Returns read data and ready to the granted requester.

---
 rtl/apb_pkg.sv | 30 +++
 rtl/apb_master_arbiter_if.sv | 51 +++++
 rtl/apb_addr_decoder.sv | 30 +++
 rtl/apb_master_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the two-requester APB master.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  localparam logic [31:0] APB_BASE_ADDR = 32'h1000_0000;
  localparam logic [31:0] APB_SLV_SIZE  = 32'h0000_1000;
  localparam logic [31:0] ERR_RDATA     = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR
  } apb_state_e;

  // Request payload latched at grant and held through the APB transfer.
  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  // Slave index width; one bit minimum so a single-slave build still elaborates.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester handshakes plus the APB bus of the shared master.
interface apb_master_arbiter_if #(
  parameter int unsigned SLV_NUM = 4
);
  import apb_pkg::*;

  logic                          req0_transfer;
  logic [APB_ADDR_W-1:0]         req0_addr;
  logic                          req0_write;
  logic [APB_DATA_W-1:0]         req0_wdata;
  logic [APB_DATA_W-1:0]         req0_rdata;
  logic                          req0_ready;

  logic                          req1_transfer;
  logic [APB_ADDR_W-1:0]         req1_addr;
  logic                          req1_write;
  logic [APB_DATA_W-1:0]         req1_wdata;
  logic [APB_DATA_W-1:0]         req1_rdata;
  logic                          req1_ready;

  logic                          req_err;

  logic [APB_ADDR_W-1:0]         PADDR;
  logic                          PWRITE;
  logic [APB_DATA_W-1:0]         PWDATA;
  logic [SLV_NUM-1:0]            PSEL;
  logic                          PENABLE;
  logic [SLV_NUM*APB_DATA_W-1:0] PRDATA;
  logic [SLV_NUM-1:0]            PREADY;

  modport master (
    input  req0_transfer, req0_addr, req0_write, req0_wdata,
    output req0_rdata, req0_ready,
    input  req1_transfer, req1_addr, req1_write, req1_wdata,
    output req1_rdata, req1_ready,
    output req_err,
    output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
    input  PRDATA, PREADY
  );

  modport slave (
    output req0_transfer, req0_addr, req0_write, req0_wdata,
    input  req0_rdata, req0_ready,
    output req1_transfer, req1_addr, req1_write, req1_wdata,
    input  req1_rdata, req1_ready,
    input  req_err,
    input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Maps a byte address onto one of SLV_NUM equal-size slave windows.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned SLV_NUM   = 4,
  parameter logic [31:0] BASE_ADDR = APB_BASE_ADDR,
  parameter logic [31:0] SLV_SIZE  = APB_SLV_SIZE,
  localparam int unsigned IDX_W    = idx_width(SLV_NUM)
) (
  input  logic [APB_ADDR_W-1:0] addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx,
  output logic [SLV_NUM-1:0]    sel
);

  // 33-bit window math so a region ending at 4 GiB does not wrap.
  localparam logic [32:0] BASE33 = {1'b0, BASE_ADDR};
  localparam logic [32:0] SIZE33 = {1'b0, SLV_SIZE};
  localparam logic [32:0] SPAN33 = 33'(SLV_NUM) * SIZE33;

  logic [32:0] off;

  always_comb begin
    off = {1'b0, addr} - BASE33;
    hit = ({1'b0, addr} >= BASE33) && (off < SPAN33);
    idx = hit ? IDX_W'(off / SIZE33) : '0;
    sel = hit ? (SLV_NUM'(1) << idx) : '0;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin two-requester APB master with address decode.
// Optional ACCESS-phase timeout abort when APB_TIMEOUT_EN is defined.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned SLV_NUM   = 4,
  parameter logic [31:0] BASE_ADDR = APB_BASE_ADDR,
  parameter logic [31:0] SLV_SIZE  = APB_SLV_SIZE
`ifdef APB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
  input logic                  clk,
  input logic                  reset,
  apb_master_arbiter_if.master bus
);

  localparam int unsigned IDX_W = idx_width(SLV_NUM);

  apb_state_e         state_q, state_d;
  apb_req_t           req_q, req_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SLV_NUM-1:0] psel_q, psel_d;
  logic               penable_q, penable_d;
`ifdef APB_TIMEOUT_EN
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               timeout_c;
`endif

  logic                  gnt_c;
  apb_req_t              cand_c;
  logic                  hit_c;
  logic [IDX_W-1:0]      idx_c;
  logic [SLV_NUM-1:0]    sel_c;
  logic                  pready_c;
  logic [APB_DATA_W-1:0] prdata_c;
  logic                  done_c;
  logic                  err_c;
  logic [APB_DATA_W-1:0] rdata_c;

  // Candidate grant: contention goes to whoever did not win last time.
  always_comb begin
    if (bus.req0_transfer && bus.req1_transfer) begin
      gnt_c = ~last_grant_q;
    end else begin
      gnt_c = bus.req1_transfer;
    end
    cand_c.addr  = gnt_c ? bus.req1_addr  : bus.req0_addr;
    cand_c.write = gnt_c ? bus.req1_write : bus.req0_write;
    cand_c.wdata = gnt_c ? bus.req1_wdata : bus.req0_wdata;
  end

  apb_addr_decoder #(
    .SLV_NUM   (SLV_NUM),
    .BASE_ADDR (BASE_ADDR),
    .SLV_SIZE  (SLV_SIZE)
  ) u_dec (
    .addr (cand_c.addr),
    .hit  (hit_c),
    .idx  (idx_c),
    .sel  (sel_c)
  );

  always_comb begin
    pready_c = bus.PREADY[idx_q];
    prdata_c = bus.PRDATA[APB_DATA_W*32'(idx_q) +: APB_DATA_W];
  end

  // Next-state logic; completion outputs are combinational off the current state.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    done_c       = 1'b0;
    err_c        = 1'b0;
    rdata_c      = ERR_RDATA;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    timeout_c    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.req0_transfer || bus.req1_transfer) begin
          req_d        = cand_c;
          grant_d      = gnt_c;
          last_grant_d = gnt_c;
          idx_d        = idx_c;
          if (hit_c) begin
            state_d = SETUP;
            psel_d  = sel_c;
          end else begin
            state_d = ERR;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      ACCESS: begin
`ifdef APB_TIMEOUT_EN
        timeout_c = (wait_cnt_q == 8'(TIMEOUT_CYC - 1));
`endif
        if (pready_c) begin
          done_c  = 1'b1;
          rdata_c = req_q.write ? '0 : prdata_c;
        end
`ifdef APB_TIMEOUT_EN
        else if (timeout_c) begin
          done_c = 1'b1;
          err_c  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
        if (done_c) begin
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
        end
      end

      ERR: begin
        done_c  = 1'b1;
        err_c   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      idx_q        <= '0;
      psel_q       <= '0;
      penable_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  // A transfer cut short by reset must never signal completion.
  logic done0_c, done1_c;
  assign done0_c = done_c && !grant_q && !reset;
  assign done1_c = done_c &&  grant_q && !reset;

  assign bus.req0_ready = done0_c;
  assign bus.req1_ready = done1_c;
  assign bus.req0_rdata = done0_c ? rdata_c : '0;
  assign bus.req1_rdata = done1_c ? rdata_c : '0;
  assign bus.req_err    = done_c && err_c && !reset;

  assign bus.PADDR   = req_q.addr;
  assign bus.PWRITE  = req_q.write;
  assign bus.PWDATA  = req_q.wdata;
  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;

endmodule
